// File: rtl/sitcpxg_tx_arbiter.sv
// Round-robin arbiter sharing the SiTCP-XG TX stream among four sources.
// Each grant lasts up to a programmable byte quantum; TX almost-full stalls the granted source.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   S_IDLE  | no grant; pick the next requester after `last`
//   S_BURST | one source granted; forward its words until exit
module sitcpxg_tx_arbiter (
  input  logic         CLK156M,
  input  logic         RSTs,
  input  logic         SiTCPXG_ESTABLISHED,
  input  logic         SiTCPXG_TX_AFULL,
  input  logic [15:0]  QUANTUM,
  input  logic [3:0]   SRC_REQ,
  input  logic [255:0] SRC_TXD,
  input  logic [15:0]  SRC_TXB,
  output logic [3:0]   SRC_RDY,
  output logic [3:0]   GNT,
  output logic [63:0]  SiTCPXG_TX_D,
  output logic [3:0]   SiTCPXG_TX_B,
  output logic [31:0]  TX_BYTES
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        est_q, est_d1_q, af_q;
  logic [1:0]  last_q, last_d;
  logic [16:0] rem_q, rem_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [63:0] tx_d_q, tx_d_d;
  logic [3:0]  tx_b_q, tx_b_d;
  logic [31:0] bytes_q, bytes_d;

  logic [3:0]  b_raw, b;
  logic [3:0]  rdy;
  logic        accept;
  logic        pick_valid;
  logic [1:0]  pick_idx, cand;

  always_comb begin
    b_raw = SRC_TXB[{last_q, 2'b00} +: 4];
    b     = (b_raw > 4'd8) ? 4'd8 : b_raw;
    rdy   = (state_q == S_BURST) ? (gnt_q & {4{~af_q & est_q}}) : 4'b0000;
    accept = rdy[last_q] && (b != 4'd0);

    // Search order last+1, last+2, ... so the most recent winner goes last.
    pick_valid = 1'b0;
    pick_idx   = last_q;
    cand       = last_q;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!pick_valid && SRC_REQ[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    rem_d   = rem_q;
    tx_d_d  = tx_d_q;
    tx_b_d  = 4'd0;
    bytes_d = bytes_q;

    if (state_q == S_IDLE) begin
      if (est_q && pick_valid) begin
        state_d = S_BURST;
        gnt_d   = 4'b0001 << pick_idx;
        last_d  = pick_idx;
        rem_d   = (QUANTUM == 16'd0) ? 17'h10000 : {1'b0, QUANTUM};
      end
    end else begin
      if (accept) rem_d = rem_q - {13'd0, b};
      if ((accept && (rem_q <= {13'd0, b})) || !SRC_REQ[last_q] || !est_q) begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
      end
    end

    if (accept) begin
      tx_d_d  = SRC_TXD[{last_q, 6'b000000} +: 64];
      tx_b_d  = b;
      bytes_d = bytes_q + {28'd0, b};
    end
    // A fresh session restarts the byte count.
    if (est_q && !est_d1_q) bytes_d = 32'd0;
  end

  always_ff @(posedge CLK156M) begin
    if (RSTs) begin
      state_q  <= S_IDLE;
      est_q    <= 1'b0;
      est_d1_q <= 1'b0;
      af_q     <= 1'b1;
      last_q   <= 2'd3;
      rem_q    <= 17'd0;
      gnt_q    <= 4'd0;
      tx_d_q   <= 64'd0;
      tx_b_q   <= 4'd0;
      bytes_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      est_q    <= SiTCPXG_ESTABLISHED;
      est_d1_q <= est_q;
      af_q     <= SiTCPXG_TX_AFULL;
      last_q   <= last_d;
      rem_q    <= rem_d;
      gnt_q    <= gnt_d;
      tx_d_q   <= tx_d_d;
      tx_b_q   <= tx_b_d;
      bytes_q  <= bytes_d;
    end
  end

  assign SRC_RDY      = rdy;
  assign GNT          = gnt_q;
  assign SiTCPXG_TX_D = tx_d_q;
  assign SiTCPXG_TX_B = tx_b_q;
  assign TX_BYTES     = bytes_q;

endmodule
